unidade_controle: RTL



---
 rtl/unidade_controle.sv | 97 +++++++++
 1 files changed

// File: rtl/unidade_controle.sv
// unidade_controle: multicycle T0-T3 control sequencer for the 16-bit bus processor
module unidade_controle (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Run,
   input  logic [15:0] DIN,
   output logic        IRin,
   output logic [7:0]  Rin,
   output logic [7:0]  Rout,
   output logic        DINout,
   output logic        Gout,
   output logic        Ain,
   output logic        Gin,
   output logic [3:0]  sinal,
   output logic        Done
);
   typedef enum logic [1:0] {T0, T1, T2, T3} state_t;
   state_t state, next;
   logic [15:0] ir;
   logic [3:0] op;
   logic [7:0] rx_oh, ry_oh;
   logic is_alu;
   assign op = ir[15:12];
   assign rx_oh = 8'b1 << ir[11:9];
   assign ry_oh = 8'b1 << ir[8:6];
   assign is_alu = op inside {[4'd5:4'd10]};
   // state register and IR, which only loads on a fetch
   always_ff @(posedge Clock or negedge Resetn)
      if (!Resetn) begin
         state <= T0;
         ir <= '0;
      end else begin
         state <= next;
         if (state == T0 && Run) ir <= DIN;
      end
   // next state and control strobes; everything is held low during reset
   always_comb begin
      next = state;
      IRin = 1'b0;
      Rin = '0;
      Rout = '0;
      DINout = 1'b0;
      Gout = 1'b0;
      Ain = 1'b0;
      Gin = 1'b0;
      sinal = '0;
      Done = 1'b0;
      case (state)
         T0: begin
            IRin = Run;
            next = Run ? T1 : T0;
         end
         T1: if (op == 4'd0) begin
            Rout = ry_oh;
            Rin = rx_oh;
            Done = 1'b1;
            next = T0;
         end else if (op == 4'd1) begin
            DINout = 1'b1;
            Rin = rx_oh;
            Done = 1'b1;
            next = T0;
         end else if (is_alu) begin
            Rout = rx_oh;
            Ain = 1'b1;
            next = T2;
         end else begin
            Done = 1'b1;
            next = T0;
         end
         T2: begin
            Rout = ry_oh;
            Gin = 1'b1;
            sinal = op;
            next = T3;
         end
         T3: begin
            Gout = 1'b1;
            Rin = rx_oh;
            Done = 1'b1;
            next = T0;
         end
         default: next = T0;
      endcase
      if (!Resetn) begin
         IRin = 1'b0;
         Rin = '0;
         Rout = '0;
         DINout = 1'b0;
         Gout = 1'b0;
         Ain = 1'b0;
         Gin = 1'b0;
         sinal = '0;
         Done = 1'b0;
      end
   end
endmodule
